// File: rtl/decode_stage.sv
// ID stage of the rv32i pipeline: decodes the fetched word and produces the immediate and control flags.
// Detects load-use hazards and holds the decoded instruction in the ID/EX register.
module decode_stage #(
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] insn_fd,
  input  logic [31:0] pc_fd,
  input  logic        fd_valid,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        stall_fd,
  output logic        valid_ex,
  output logic [31:0] insn_ex,
  output logic [31:0] pc_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic [31:0] imm_ex,
  output logic [3:0]  alu_op_ex,
  output logic [2:0]  funct3_ex,
  output logic        reg_we_ex,
  output logic        mem_rd_ex,
  output logic        mem_wr_ex,
  output logic        branch_ex,
  output logic        jal_ex,
  output logic        jalr_ex,
  output logic        use_imm_ex,
  output logic        use_pc_ex,
  output logic        illegal_ex
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [3:0]  w_alu;
  logic        w_we_fmt, w_mem_rd, w_mem_wr, w_branch, w_jal, w_jalr;
  logic        w_use_imm, w_use_pc, w_illegal, w_rs1_used, w_rs2_used;
  logic [8:0]  w_flags;
  logic        w_hazard;

  // Flag vector order: {reg_we, mem_rd, mem_wr, branch, jal, jalr, use_imm, use_pc, illegal}
  logic        r_valid;
  logic [31:0] r_insn, r_pc, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [3:0]  r_alu;
  logic [2:0]  r_f3;
  logic [8:0]  r_flags;

  assign w_imm_i = {{20{insn_fd[31]}}, insn_fd[31:20]};
  assign w_imm_s = {{20{insn_fd[31]}}, insn_fd[31:25], insn_fd[11:7]};
  assign w_imm_b = {{19{insn_fd[31]}}, insn_fd[31], insn_fd[7], insn_fd[30:25], insn_fd[11:8], 1'b0};
  assign w_imm_u = {insn_fd[31:12], 12'h000};
  assign w_imm_j = {{11{insn_fd[31]}}, insn_fd[31], insn_fd[19:12], insn_fd[20], insn_fd[30:21], 1'b0};

  // Opcode decode into format-specific immediate, ALU op, flags and source usage.
  always_comb begin
    w_imm      = 32'h0000_0000;
    w_rs1      = insn_fd[19:15];
    w_alu      = 4'b0000;
    w_we_fmt   = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_branch   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_use_imm  = 1'b0;
    w_use_pc   = 1'b0;
    w_illegal  = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (insn_fd[6:0])
      OP_R: begin
        w_alu      = {insn_fd[30], insn_fd[14:12]};
        w_we_fmt   = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_IALU: begin
        w_imm      = w_imm_i;
        w_alu      = {(insn_fd[14:12] == 3'b101) & insn_fd[30], insn_fd[14:12]};
        w_we_fmt   = 1'b1;
        w_use_imm  = 1'b1;
        w_rs1_used = 1'b1;
      end
      OP_LOAD: begin
        w_imm      = w_imm_i;
        w_we_fmt   = 1'b1;
        w_mem_rd   = 1'b1;
        w_use_imm  = 1'b1;
        w_rs1_used = 1'b1;
      end
      OP_STORE: begin
        w_imm      = w_imm_s;
        w_mem_wr   = 1'b1;
        w_use_imm  = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        w_imm      = w_imm_b;
        w_branch   = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_LUI: begin
        w_imm      = w_imm_u;
        w_rs1      = 5'd0;
        w_we_fmt   = 1'b1;
        w_use_imm  = 1'b1;
      end
      OP_AUIPC: begin
        w_imm      = w_imm_u;
        w_we_fmt   = 1'b1;
        w_use_imm  = 1'b1;
        w_use_pc   = 1'b1;
      end
      OP_JAL: begin
        w_imm      = w_imm_j;
        w_we_fmt   = 1'b1;
        w_jal      = 1'b1;
        w_use_imm  = 1'b1;
        w_use_pc   = 1'b1;
      end
      OP_JALR: begin
        w_imm      = w_imm_i;
        w_we_fmt   = 1'b1;
        w_jalr     = 1'b1;
        w_use_imm  = 1'b1;
        w_rs1_used = 1'b1;
      end
      default: begin
        w_illegal  = 1'b1;
      end
    endcase
  end

  assign w_flags = {w_we_fmt & (insn_fd[11:7] != 5'd0), w_mem_rd, w_mem_wr, w_branch,
                    w_jal, w_jalr, w_use_imm, w_use_pc, w_illegal};

  // A load in ID/EX whose destination feeds the instruction now in decode must wait one cycle.
  assign w_hazard = r_valid & r_flags[7] & (r_rd != 5'd0) & fd_valid &
                    ((w_rs1_used & (w_rs1 == r_rd)) | (w_rs2_used & (insn_fd[24:20] == r_rd)));

  assign stall_fd = ~rst & ~flush & (ex_stall | w_hazard);

  // ID/EX pipeline register: reset, flush, hold, bubble or load, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_insn  <= NOP_INSN;
      r_pc    <= 32'h0000_0000;
      r_imm   <= 32'h0000_0000;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_alu   <= 4'b0000;
      r_f3    <= 3'b000;
      r_flags <= 9'b0;
    end else if (flush || (!ex_stall && w_hazard)) begin
      r_valid <= 1'b0;
      r_insn  <= NOP_INSN;
      r_flags <= 9'b0;
    end else if (!ex_stall) begin
      r_valid <= fd_valid;
      r_insn  <= insn_fd;
      r_pc    <= pc_fd;
      r_imm   <= w_imm;
      r_rs1   <= w_rs1;
      r_rs2   <= insn_fd[24:20];
      r_rd    <= insn_fd[11:7];
      r_alu   <= w_alu;
      r_f3    <= insn_fd[14:12];
      r_flags <= fd_valid ? w_flags : 9'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign valid_ex   = r_valid;
  assign insn_ex    = r_insn;
  assign pc_ex      = r_pc;
  assign imm_ex     = r_imm;
  assign rs1_ex     = r_rs1;
  assign rs2_ex     = r_rs2;
  assign rd_ex      = r_rd;
  assign alu_op_ex  = r_alu;
  assign funct3_ex  = r_f3;
  assign reg_we_ex  = r_flags[8];
  assign mem_rd_ex  = r_flags[7];
  assign mem_wr_ex  = r_flags[6];
  assign branch_ex  = r_flags[5];
  assign jal_ex     = r_flags[4];
  assign jalr_ex    = r_flags[3];
  assign use_imm_ex = r_flags[2];
  assign use_pc_ex  = r_flags[1];
  assign illegal_ex = r_flags[0];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected ID/EX contents are queued with each stimulus
// cycle and compared after the clock edge that loads them.
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [8:0] F_WE  = 9'h100, F_MRD = 9'h080, F_MWR = 9'h040, F_BR  = 9'h020;
  localparam logic [8:0] F_IMM = 9'h004, F_ILL = 9'h001, F_NONE = 9'h000;
  // field mask bits: 0 insn, 1 pc, 2 rs1, 3 rs2, 4 rd, 5 imm, 6 alu, 7 f3
  localparam logic [7:0] M_ALL = 8'hFF, M_NORS2 = 8'hF7, M_NORD = 8'hEF, M_LUI = 8'h77;

  localparam logic [31:0] I_ADDI  = 32'h00500093, I_LUI = 32'h123452B7, I_SW = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3, I_LW  = 32'h0000A103, I_ADD = 32'h001101B3;
  localparam logic [31:0] I_ADD4  = 32'h001201B3, I_ILL = 32'h0000007F, I_ADDI0 = 32'h00100013;

  typedef struct {
    logic        valid;
    logic [8:0]  flags;
    logic [7:0]  m;
    logic [31:0] insn, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [2:0]  f3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, fd_valid, flush, ex_stall;
  logic [31:0] insn_fd, pc_fd;
  logic        stall_fd, valid_ex;
  logic [31:0] insn_ex, pc_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [3:0]  alu_op_ex;
  logic [2:0]  funct3_ex;
  logic        reg_we_ex, mem_rd_ex, mem_wr_ex, branch_ex, jal_ex, jalr_ex;
  logic        use_imm_ex, use_pc_ex, illegal_ex;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .insn_fd(insn_fd), .pc_fd(pc_fd), .fd_valid(fd_valid),
    .flush(flush), .ex_stall(ex_stall), .stall_fd(stall_fd), .valid_ex(valid_ex),
    .insn_ex(insn_ex), .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .imm_ex(imm_ex), .alu_op_ex(alu_op_ex), .funct3_ex(funct3_ex),
    .reg_we_ex(reg_we_ex), .mem_rd_ex(mem_rd_ex), .mem_wr_ex(mem_wr_ex),
    .branch_ex(branch_ex), .jal_ex(jal_ex), .jalr_ex(jalr_ex),
    .use_imm_ex(use_imm_ex), .use_pc_ex(use_pc_ex), .illegal_ex(illegal_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [8:0] fl, input logic [7:0] m,
                              input logic [31:0] insn, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [3:0] alu, input logic [2:0] f3);
    exp_t e;
    e.valid = v; e.flags = fl; e.m = m; e.insn = insn; e.pc = pc; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu; e.f3 = f3;
    return e;
  endfunction

  // One pipeline cycle: drive inputs, check stall_fd, clock, then compare ID/EX with the queued entry.
  task automatic cyc(input logic [31:0] insn, input logic [31:0] pc, input logic v,
                     input logic fl, input logic es, input logic r, input logic exp_stall,
                     input exp_t e);
    exp_t g;
    rst = r; insn_fd = insn; pc_fd = pc; fd_valid = v; flush = fl; ex_stall = es;
    q.push_back(e);
    #1;
    check_value($sformatf("stall_fd@%h", pc), 32'(stall_fd), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check_value("queue_empty", 32'd1, 32'd0);
    end else begin
      g = q.pop_front();
      check_value($sformatf("valid@%h", pc), 32'(valid_ex), 32'(g.valid));
      check_value($sformatf("flags@%h", pc),
                  32'({reg_we_ex, mem_rd_ex, mem_wr_ex, branch_ex, jal_ex, jalr_ex,
                       use_imm_ex, use_pc_ex, illegal_ex}), 32'(g.flags));
      if (g.m[0]) check_value($sformatf("insn@%h", pc), insn_ex, g.insn);
      if (g.m[1]) check_value($sformatf("pc@%h", pc), pc_ex, g.pc);
      if (g.m[2]) check_value($sformatf("rs1@%h", pc), 32'(rs1_ex), 32'(g.rs1));
      if (g.m[3]) check_value($sformatf("rs2@%h", pc), 32'(rs2_ex), 32'(g.rs2));
      if (g.m[4]) check_value($sformatf("rd@%h", pc), 32'(rd_ex), 32'(g.rd));
      if (g.m[5]) check_value($sformatf("imm@%h", pc), imm_ex, g.imm);
      if (g.m[6]) check_value($sformatf("alu@%h", pc), 32'(alu_op_ex), 32'(g.alu));
      if (g.m[7]) check_value($sformatf("f3@%h", pc), 32'(funct3_ex), 32'(g.f3));
    end
  endtask

  initial begin
    exp_t e_rst, e_bub, e_dead, e_addi, e_lui, e_sw, e_lw, e_add;
    e_rst  = mk(1'b0, F_NONE, M_ALL, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 3'd0);
    e_bub  = mk(1'b0, F_NONE, 8'h01, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 3'd0);
    e_dead = mk(1'b0, F_NONE, 8'h00, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 3'd0);

    // reset with arbitrary inputs, including a pending stall
    cyc(I_LW, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, e_rst);
    cyc(I_ADD, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, e_rst);

    // ALU and immediate formats
    e_addi = mk(1'b1, F_WE | F_IMM, M_NORS2, I_ADDI, 32'h100, 5'd0, 5'd0, 5'd1, 32'd5, 4'h0, 3'd0);
    cyc(I_ADDI, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_addi);
    e_lui = mk(1'b1, F_WE | F_IMM, M_LUI, I_LUI, 32'h104, 5'd0, 5'd0, 5'd5, 32'h12345000, 4'h0, 3'd0);
    cyc(I_LUI, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lui);
    cyc(I_SW, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_MWR | F_IMM, M_NORD, I_SW, 32'h108, 5'd1, 5'd2, 5'd0, 32'd8, 4'h0, 3'd2));
    cyc(I_BEQ, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_BR, M_NORD, I_BEQ, 32'h10C, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'h0, 3'd0));

    // load-use on rs1: one stall cycle, one bubble, then the add
    e_lw = mk(1'b1, F_WE | F_MRD | F_IMM, M_NORS2, I_LW, 32'h110, 5'd1, 5'd0, 5'd2, 32'h0, 4'h0, 3'd2);
    cyc(I_LW, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_ADD, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e_bub);
    e_add = mk(1'b1, F_WE, M_ALL, I_ADD, 32'h114, 5'd2, 5'd1, 5'd3, 32'h0, 4'h0, 3'd0);
    cyc(I_ADD, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_add);

    // independent add after a load: no stall
    e_lw.pc = 32'h118;
    cyc(I_LW, 32'h118, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_ADD4, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_WE, M_ALL, I_ADD4, 32'h11C, 5'd4, 5'd1, 5'd3, 32'h0, 4'h0, 3'd0));

    // load-use through rs2 of a store
    e_lw.pc = 32'h120;
    cyc(I_LW, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_SW, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e_bub);
    cyc(I_SW, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_MWR | F_IMM, M_NORD, I_SW, 32'h124, 5'd1, 5'd2, 5'd0, 32'd8, 4'h0, 3'd2));

    // flush beats ex_stall and hazard together
    e_lw.pc = 32'h128;
    cyc(I_LW, 32'h128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_ADD, 32'h12C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e_dead);

    // back-pressure: three held cycles, then the waiting lui loads
    e_addi.pc = 32'h130;
    cyc(I_ADDI, 32'h130, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_addi);
    for (int i = 0; i < 3; i++) begin
      cyc(I_LUI, 32'h134, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, e_addi);
    end
    e_lui.pc = 32'h134;
    cyc(I_LUI, 32'h134, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lui);

    // invalid fetch slot behind a load: no hazard, nothing live
    e_lw.pc = 32'h138;
    cyc(I_LW, 32'h138, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_ADD, 32'h13C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_dead);

    // illegal opcode and a write to x0
    cyc(I_ILL, 32'h140, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_ILL, 8'h03, I_ILL, 32'h140, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 3'd0));
    cyc(I_ADDI0, 32'h144, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        mk(1'b1, F_IMM, M_NORS2, I_ADDI0, 32'h144, 5'd0, 5'd0, 5'd0, 32'd1, 4'h0, 3'd0));

    // reset in the middle of a load-use hazard clears everything
    e_lw.pc = 32'h148;
    cyc(I_LW, 32'h148, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_lw);
    cyc(I_ADD, 32'h14C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, e_rst);
    e_add.pc = 32'h14C;
    cyc(I_ADD, 32'h14C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_add);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
